// File: rtl/instr_encoder_if.sv
// Handshake and data bundle for instr_encoder: decoded-field input side
// (valid/ready) and FIFO-head output side (valid/ready).
interface instr_encoder_if #(
  parameter int LEN = 32
);
  logic           in_valid;
  logic           in_ready;
  logic [5:0]     inst_type;
  logic [6:0]     opcode;
  logic [2:0]     func3;
  logic [6:0]     func7;
  logic [4:0]     rd;
  logic [4:0]     rs1;
  logic [4:0]     rs2;
  logic [LEN-1:0] immediate;
  logic           out_valid;
  logic           out_ready;
  logic [LEN-1:0] instruction;
  logic           range_err;

  // Producer of decoded fields and consumer of encoded words
  modport master (
    output in_valid, inst_type, opcode, func3, func7, rd, rs1, rs2, immediate, out_ready,
    input  in_ready, out_valid, instruction, range_err
  );

  // The encoder itself
  modport slave (
    input  in_valid, inst_type, opcode, func3, func7, rd, rs1, rs2, immediate, out_ready,
    output in_ready, out_valid, instruction, range_err
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: registers decoded fields (stage 1), packs them
// into a 32-bit word (stage 2, combinational) and queues word + error bit in
// a small output FIFO.
// Optional feature macro: ENCODER_RANGE_CHECK_EN enables immediate range
// checking; without it only a non-one-hot inst_type flags an error.
module instr_encoder #(
  parameter int LEN        = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            chip_enable,
  instr_encoder_if.slave  bus,
  output logic [7:0]      err_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [5:0] {
    FMT_R = 6'b100000,
    FMT_I = 6'b010000,
    FMT_S = 6'b001000,
    FMT_B = 6'b000100,
    FMT_U = 6'b000010,
    FMT_J = 6'b000001
  } fmt_e;

  fmt_e           s1_type;
  logic           s1_valid;
  logic [6:0]     s1_opcode;
  logic [2:0]     s1_func3;
  logic [6:0]     s1_func7;
  logic [4:0]     s1_rd;
  logic [4:0]     s1_rs1;
  logic [4:0]     s1_rs2;
  logic [LEN-1:0] s1_imm;

  logic [LEN-1:0] enc_word;
  logic           type_err;
  logic           range_bad;
  logic           enc_err;

  logic [LEN:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           full;
  logic           pop;
  logic           s1_move;
  logic           accept;

  assign full        = (count == (AW+1)'(FIFO_DEPTH));
  assign bus.out_valid = (count != '0);
  assign pop         = bus.out_valid && bus.out_ready;
  assign s1_move     = s1_valid && chip_enable && (!full || pop);
  assign bus.in_ready = chip_enable && (!s1_valid || s1_move);
  assign accept      = bus.in_valid && bus.in_ready;

  // Stage 1: capture decoded fields on accept, release when moved into the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_type   <= FMT_R;
      s1_opcode <= '0;
      s1_func3  <= '0;
      s1_func7  <= '0;
      s1_rd     <= '0;
      s1_rs1    <= '0;
      s1_rs2    <= '0;
      s1_imm    <= '0;
    end else if (accept) begin
      s1_valid  <= 1'b1;
      s1_type   <= fmt_e'(bus.inst_type);
      s1_opcode <= bus.opcode;
      s1_func3  <= bus.func3;
      s1_func7  <= bus.func7;
      s1_rd     <= bus.rd;
      s1_rs1    <= bus.rs1;
      s1_rs2    <= bus.rs2;
      s1_imm    <= bus.immediate;
    end else if (s1_move) begin
      s1_valid  <= 1'b0;
    end
  end

  // Stage 2: pack fields by format; anything not one-hot encodes as zero with error
  always_comb begin
    enc_word = '0;
    type_err = 1'b0;
    case (s1_type)
      FMT_R: enc_word = {s1_func7, s1_rs2, s1_rs1, s1_func3, s1_rd, s1_opcode};
      FMT_I: enc_word = {s1_imm[11:0], s1_rs1, s1_func3, s1_rd, s1_opcode};
      FMT_S: enc_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_func3, s1_imm[4:0], s1_opcode};
      FMT_B: enc_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_func3,
                         s1_imm[4:1], s1_imm[11], s1_opcode};
      FMT_U: enc_word = {s1_imm[31:12], s1_rd, s1_opcode};
      FMT_J: enc_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_opcode};
      default: type_err = 1'b1;
    endcase
  end

`ifdef ENCODER_RANGE_CHECK_EN
  // Range check: upper bits must be a pure sign extension; B/J offsets must be even
  always_comb begin
    range_bad = 1'b0;
    case (s1_type)
      FMT_I, FMT_S: range_bad = !((s1_imm[LEN-1:11] == '0) || (s1_imm[LEN-1:11] == '1));
      FMT_B: range_bad = !((s1_imm[LEN-1:12] == '0) || (s1_imm[LEN-1:12] == '1)) || s1_imm[0];
      FMT_J: range_bad = !((s1_imm[LEN-1:20] == '0) || (s1_imm[LEN-1:20] == '1)) || s1_imm[0];
      FMT_U: range_bad = (s1_imm[11:0] != '0);
      default: range_bad = 1'b0;
    endcase
  end
`else
  assign range_bad = 1'b0;
`endif

  assign enc_err = type_err || range_bad;

  // FIFO storage: write encoded word with its error bit when stage 1 moves
  always_ff @(posedge clk) begin
    if (s1_move) begin
      fifo_mem[wr_ptr] <= {enc_err, enc_word};
    end
  end

  // FIFO pointers, occupancy and saturating error counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err_count <= '0;
    end else begin
      if (s1_move) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({s1_move, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (s1_move && enc_err && (err_count != 8'hFF)) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

  // Head outputs read zero while empty so the memory needs no reset
  always_comb begin
    bus.instruction = '0;
    bus.range_err   = 1'b0;
    if (bus.out_valid) begin
      bus.instruction = fifo_mem[rd_ptr][LEN-1:0];
      bus.range_err   = fifo_mem[rd_ptr][LEN];
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected words are computed by a
// shift/mask model at accept time and compared when the FIFO head pops.
module tb_instr_encoder;

`ifdef ENCODER_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       chip_enable;
  logic [7:0] err_count;

  instr_encoder_if #(.LEN(32)) bus ();

  instr_encoder #(.LEN(32), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .chip_enable (chip_enable),
    .bus         (bus),
    .err_count   (err_count)
  );

  int          n_compared;
  int          n_mismatched;
  int          exp_err;
  logic [32:0] sb[$];
  logic [32:0] mon_e;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference encoder: {err, word}
  function automatic logic [32:0] model(input logic [5:0] t, input logic [6:0] op,
                                        input logic [2:0] f3, input logic [6:0] f7,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [31:0] imm);
    logic [31:0] w;
    logic        bad;
    int          s;
    s   = $signed(imm);
    w   = 32'h0;
    bad = 1'b0;
    case (t)
      6'b100000: w = (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) |
                     (32'(f3) << 12) | (32'(rd) << 7) | 32'(op);
      6'b010000: begin
        w = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) |
            (32'(rd) << 7) | 32'(op);
        bad = (s < -2048) || (s > 2047);
      end
      6'b001000: begin
        w = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) |
            (32'(f3) << 12) | ((imm & 32'h1F) << 7) | 32'(op);
        bad = (s < -2048) || (s > 2047);
      end
      6'b000100: begin
        w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) |
            (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) |
            (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'(op);
        bad = (s < -4096) || (s > 4094) || ((imm & 32'h1) != 0);
      end
      6'b000010: begin
        w = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
        bad = (imm & 32'hFFF) != 0;
      end
      6'b000001: begin
        w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
            (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) |
            (32'(rd) << 7) | 32'(op);
        bad = (s < -1048576) || (s > 1048574) || ((imm & 32'h1) != 0);
      end
      default: return {1'b1, 32'h0};
    endcase
    if (!RC) bad = 1'b0;
    return {bad, w};
  endfunction

  // Monitor: pop/compare before push so an empty queue never self-matches
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_pop", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("word", bus.instruction, mon_e[31:0]);
          check("range_err", bus.range_err, mon_e[32]);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        mon_e = model(bus.inst_type, bus.opcode, bus.func3, bus.func7,
                      bus.rd, bus.rs1, bus.rs2, bus.immediate);
        sb.push_back(mon_e);
        if (mon_e[32] && exp_err < 255) exp_err++;
      end
    end
  end

  // Present one beat for one cycle; called #1 after a rising edge
  task automatic send(input logic [5:0] t, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, output bit acc);
    bus.inst_type = t;
    bus.opcode    = op;
    bus.func3     = f3;
    bus.func7     = f7;
    bus.rd        = rd;
    bus.rs1       = rs1;
    bus.rs2       = rs2;
    bus.immediate = imm;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    acc = bus.in_ready;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_wait(input logic [5:0] t, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) begin
      send(t, op, f3, f7, rd, rs1, rs2, imm, acc);
    end
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (sb.size() != 0 || bus.out_valid); i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_done", (sb.size() == 0 && !bus.out_valid), 1);
  endtask

  // Accept an ADDI, expect it at the head exactly one edge after the accept edge
  task automatic latency_test(input string tag);
    bit acc;
    bus.out_ready = 1'b0;
    send(6'b010000, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, acc);
    check({tag, "_accept"}, acc, 1);
    check({tag, "_not_yet"}, bus.out_valid, 0);
    @(posedge clk);
    #1;
    check({tag, "_valid"}, bus.out_valid, 1);
    check({tag, "_word"}, bus.instruction, 32'h00500093);
    check({tag, "_err"}, bus.range_err, 0);
    bus.out_ready = 1'b1;
    drain();
  endtask

  initial begin
    bit          acc;
    int          n_acc;
    logic [31:0] r;
    logic [31:0] imm;
    logic [5:0]  t;
    logic [5:0]  types [8];

    types = '{6'b100000, 6'b010000, 6'b001000, 6'b000100,
              6'b000010, 6'b000001, 6'b000000, 6'b010100};
    n_compared   = 0;
    n_mismatched = 0;
    exp_err      = 0;
    rst_n        = 1'b0;
    chip_enable  = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.inst_type = '0;
    bus.opcode = '0;
    bus.func3 = '0;
    bus.func7 = '0;
    bus.rd = '0;
    bus.rs1 = '0;
    bus.rs2 = '0;
    bus.immediate = '0;
    #2;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_instruction", bus.instruction, 0);
    check("rst_range_err", bus.range_err, 0);
    check("rst_err_count", err_count, 0);
    check("rst_in_ready_ce1", bus.in_ready, 1);
    chip_enable = 1'b0;
    #1;
    check("rst_in_ready_ce0", bus.in_ready, 0);
    chip_enable = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    latency_test("lat");

    // Directed encodings, including range-check boundaries
    send_wait(6'b000100, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd8);
    send_wait(6'b000001, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    send_wait(6'b010000, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    send_wait(6'b000001, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd3);
    send_wait(6'b000100, 7'b1100011, 3'd1, 7'd0, 5'd0, 5'd3, 5'd4, 32'd4094);
    send_wait(6'b010000, 7'b0000011, 3'd2, 7'd0, 5'd5, 5'd6, 5'd0, -32'sd2048);
    drain();
    check("err_count_range", err_count, RC ? 2 : 0);
    send_wait(6'b000000, 7'b0110011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0);
    drain();
    check("err_count_type", err_count, RC ? 3 : 1);
    check("err_count_model", err_count, exp_err);

    // Backpressure: 5 in flight, sixth refused
    bus.out_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      send(6'b100000, 7'b0110011, 3'(i), 7'(i * 3), 5'(i + 1), 5'(i + 7), 5'(i + 13), 32'd0, acc);
      if (acc) n_acc++;
    end
    check("bp_accepts", n_acc, 5);
    check("bp_in_ready", bus.in_ready, 0);
    check("bp_head", bus.instruction, sb[0][31:0]);
    @(posedge clk);
    #1;
    check("bp_head_hold", bus.instruction, sb[0][31:0]);

    // Full FIFO with stage 1 occupied: pop and stage-1 move in the same cycle
    bus.out_ready = 1'b1;
    #1;
    check("full_pushpop_ready", bus.in_ready, 1);
    send(6'b000010, 7'b0110111, 3'd0, 7'd0, 5'd9, 5'd0, 5'd0, 32'hABCDE000, acc);
    check("full_pushpop_accept", acc, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stream_valid", bus.out_valid, 1);
    end
    drain();

    // Random traffic with enable, backpressure and bad formats
    for (int i = 0; i < 80; i++) begin
      r = $urandom;
      case ($urandom_range(0, 3))
        0: imm = r;
        1: imm = {{18{r[13]}}, r[13:0]};
        2: imm = {{10{r[21]}}, r[21:0]};
        default: imm = {r[31:12], 12'h0};
      endcase
      t = types[$urandom_range(0, 7)];
      chip_enable   = ($urandom_range(0, 4) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.inst_type = t;
      bus.opcode    = 7'($urandom);
      bus.func3     = 3'($urandom);
      bus.func7     = 7'($urandom);
      bus.rd        = 5'($urandom);
      bus.rs1       = 5'($urandom);
      bus.rs2       = 5'($urandom);
      bus.immediate = imm;
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    chip_enable   = 1'b1;
    bus.out_ready = 1'b1;
    drain();
    check("err_count_random", err_count, exp_err);

    // Reset with words queued
    bus.out_ready = 1'b0;
    send_wait(6'b000011, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    send_wait(6'b010000, 7'b0010011, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd7);
    send_wait(6'b010000, 7'b0010011, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd9);
    check("pre_reset_valid", bus.out_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_err_count", err_count, 0);
    check("reset_instruction", bus.instruction, 0);
    check("reset_in_ready", bus.in_ready, 1);
    sb.delete();
    exp_err = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    latency_test("post_reset");
    check("post_reset_err_count", err_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Pipelined RISC-V (RV32I) instruction encoder: the inverse of the immediate generator. Accepts decoded fields (format, opcode, func3/func7, registers, sign-extended immediate) over a valid/ready handshake and packs them into a 32-bit instruction word. Feeds a 4-deep output FIFO drained by the instruction-memory loader / debug injector. Optional range checking flags immediates that do not fit their format.

## Interface
- LEN, 32, instruction and immediate width
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥2)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- chip_enable  in  1  gates acceptance and stage-1 advance
- in_valid  in  1  input fields valid
- in_ready  out  1  encoder can accept this cycle
- inst_type  in  6  one-hot: 100000 R, 010000 I, 001000 S, 000100 B, 000010 U, 000001 J
- opcode  in  7  instruction[6:0]
- func3  in  3  instruction[14:12]
- func7  in  7  instruction[31:25] (R only)
- rd, rs1, rs2  in  5 each  register indices
- immediate  in  LEN  signed byte-offset / value (B, J include bit 0)
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer pops head when out_valid
- instruction  out  LEN  FIFO head word
- range_err  out  1  head entry failed range check (meaningful with out_valid)
- err_count  out  8  saturating count of errored entries written

## Operation
- Stage 1: on in_valid && in_ready, register all fields; s1_valid=1.
- Stage 2: combinational encode of stage-1 register; write word + err bit into FIFO when s1_move.
- s1_move = s1_valid && chip_enable && (count < FIFO_DEPTH || pop); pop = out_valid && out_ready.
- in_ready = chip_enable && (!s1_valid || s1_move).
- Packing (unused fields zero): R {func7,rs2,rs1,func3,rd,opcode}; I {imm[11:0],rs1,func3,rd,opcode}; S {imm[11:5],rs2,rs1,func3,imm[4:0],opcode}; B {imm[12],imm[10:5],rs2,rs1,func3,imm[4:1],imm[11],opcode}; U {imm[31:12],rd,opcode}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}.
- Non-one-hot inst_type: word = 0, err = 1 (err forced even without range check).
- Range rules: I/S imm ∈ [−2048, 2047]; B ∈ [−4096, 4094], even; J ∈ [−2^20, 2^20−2], even; U imm[11:0] == 0; R never errors. Out-of-range words still emitted, field bits truncated.
- err_count += 1 on each FIFO write with err=1, saturates at 255.
- FIFO: in-order; simultaneous push and pop when full is legal (count unchanged); pops continue while chip_enable low.

## Timing
- Reset (async, rst_n low): s1_valid=0, FIFO empty, out_valid=0, instruction=0, range_err=0, err_count=0; in_ready follows chip_enable.
- Latency: accept at edge N → FIFO write at edge N+1 → out_valid high after N+1 (2 cycles), if not backpressured.
- Throughput: 1 word/cycle with out_ready high.
- Capacity: FIFO_DEPTH + 1 words in flight; in_ready falls after the (FIFO_DEPTH+1)th accept with out_ready low.
- in_ready has a combinational path from out_ready.
- Reset mid-operation discards all in-flight words immediately.
- instruction/range_err hold while out_valid && !out_ready.

## Configuration
- ENCODER_RANGE_CHECK_EN defined: range rules applied, range_err/err_count as above.
- Undefined: range checks removed; err bit set only for non-one-hot inst_type; packing unchanged.

## Test plan
- I: opcode 0010011, func3 0, rd 1, rs1 0, imm 5 → instruction 0x00500093, out_valid 2 cycles after accept, range_err 0.
- B: opcode 1100011, rs1 1, rs2 2, func3 0, imm −8 → 0xFE208CE3; J: opcode 1101111, rd 1, imm 2048 → 0x001000EF.
- Range (macro on): I imm 2048 → 0x80000093, range_err 1, err_count 1; J imm 3 → range_err 1, err_count 2; macro off → both range_err 0.
- Backpressure: out_ready 0, 6 back-to-back valids → 5 accepted, in_ready 0; out_ready 1 → 5 words out in order, one per cycle.
- Full push/pop: FIFO full, s1_valid, out_ready 1 → stage 1 moves same cycle, count stays 4, no word lost.
- Reset: rst_n low with 3 queued → out_valid 0 asynchronously, err_count 0; first post-reset accept emerges 2 cycles later.
